uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter, with XON/XOFF flow control.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter logic [7:0] XOFF_CHAR = 8'h5A,
  parameter logic [7:0] XON_CHAR = 8'h7A
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 tx_write_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 blocked_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, LOCKED, ISSUE, HOLD, WAIT} state_t;
  state_t state, state_n;
  logic [IW-1:0] last_owner, owner, win, cand, sel;
  logic [NUM_REQ-1:0] grant_q, ready_int;
  logic [7:0] data_q;
  logic [7:0] bytes [NUM_REQ];
  logic last_q, blocked_q, found, open_arb, open_own, exit_wait, xfer;
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) bytes[k] = req_data_i[8*k +: 8];
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_owner) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  // A WAIT that sees the transmitter free already behaves as its exit state, so a new byte can go out the same cycle.
  always_comb begin
    exit_wait = state == WAIT && !tx_busy_i;
    open_arb = state == IDLE || (exit_wait && last_q);
    open_own = state == LOCKED || (exit_wait && !last_q);
    sel = open_arb ? win : owner;
    ready_int = (tx_busy_i || blocked_q) ? '0
              : open_arb ? (found ? NUM_REQ'(1) << win : '0)
              : open_own ? grant_q & req_valid_i : '0;
    xfer = |ready_int;
  end
  always_comb begin
    state_n = xfer ? ISSUE
            : state == ISSUE ? HOLD
            : state == HOLD ? WAIT
            : exit_wait ? (last_q ? IDLE : LOCKED)
            : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // last_owner moves at the last byte's transfer so the WAIT-exit arbitration already starts after that owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= 8'h00;
      last_q <= 1'b0;
      owner <= '0;
      grant_q <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      blocked_q <= 1'b0;
    end else begin
      if (xfer) begin
        data_q <= bytes[sel];
        last_q <= req_last_i[sel];
        owner <= sel;
        grant_q <= NUM_REQ'(1) << sel;
        if (req_last_i[sel]) last_owner <= sel;
      end else if (exit_wait && last_q) begin
        grant_q <= '0;
      end
      if (rx_valid_i && rx_data_i == XOFF_CHAR) blocked_q <= 1'b1;
      else if (rx_valid_i && rx_data_i == XON_CHAR) blocked_q <= 1'b0;
    end
  end
  assign req_ready_o = ready_int & {NUM_REQ{~reset}};
  assign tx_write_o = state == ISSUE;
  assign tx_data_o = data_q;
  assign grant_o = grant_q;
  assign blocked_o = blocked_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario tasks with hand-computed expectations for uart_tx_arbiter.
module tb_uart_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0] req_last = '0;
  logic [2:0] req_ready;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic tx_write;
  logic [7:0] tx_data;
  logic tx_busy = 1'b0;
  logic [2:0] grant;
  logic blocked;
  int errors = 0;
  int checks = 0;
  uart_tx_arbiter dut (
    .clock(clock), .reset(reset), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_write_o(tx_write), .tx_data_o(tx_data), .tx_busy_i(tx_busy), .grant_o(grant), .blocked_o(blocked)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #2;
    rx_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    tx_busy = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    req_last = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", tx_write); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL reset_blocked got=%b exp=0", blocked); end
  endtask
  task automatic test_single();
    do_reset();
    req_valid = 3'b001; req_data = 24'h000041; req_last = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_grant0 got=%b exp=000", grant); end
    tick();
    req_valid = 3'b000;
    #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL single_issue got=%b/%h exp=1/41", tx_write, tx_data); end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant1 got=%b exp=001", grant); end
    tick(); #1;
    checks++; if (tx_write !== 1'b0 || grant !== 3'b001) begin errors++; $display("FAIL single_hold got=%b/%b exp=0/001", tx_write, grant); end
    tick(); #1;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_wait_grant got=%b exp=001", grant); end
    tick(); #1;
    checks++; if (grant !== 3'b000 || tx_write !== 1'b0 || tx_data !== 8'h41) begin errors++; $display("FAIL single_idle got=%b/%b/%h exp=000/0/41", grant, tx_write, tx_data); end
  endtask
  task automatic test_round_robin();
    logic [7:0] exp [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};
    int n = 0;
    do_reset();
    req_valid = 3'b111; req_last = 3'b111; req_data = 24'hA2A1A0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (tx_write) begin
        checks++;
        if (n >= 4 || tx_data !== exp[n & 3] || c != 1 + 3 * n) begin
          errors++; $display("FAIL rr_strobe n=%0d got=%h@%0d exp=%h@%0d", n, tx_data, c, exp[n & 3], 1 + 3 * n);
        end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
  endtask
  task automatic test_packet_lock();
    logic [7:0] exp [4] = '{8'h10, 8'h11, 8'h12, 8'hC2};
    int n = 0;
    int n1 = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_data = {8'hC2, 8'h10 + 8'(n1), 8'hB0};
      req_last = {1'b1, n1 == 2, 1'b1};
      req_valid = c == 0 ? 3'b010 : n1 < 3 ? 3'b111 : 3'b101;
      #1;
      if (c == 0) begin
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL lock_first got=%b exp=010", req_ready); end
      end
      if (c == 5) begin
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL lock_grant got=%b exp=010", grant); end
      end
      if (tx_write) begin
        checks++;
        if (n >= 4 || tx_data !== exp[n & 3] || c != 1 + 3 * n) begin
          errors++; $display("FAIL lock_strobe n=%0d got=%h@%0d exp=%h@%0d", n, tx_data, c, exp[n & 3], 1 + 3 * n);
        end
        n++;
      end
      if (req_ready[1]) n1++;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL lock_count got=%0d exp=4", n); end
  endtask
  task automatic test_flow_control();
    do_reset();
    req_valid = 3'b001; req_data = 24'h000031; req_last = 3'b000;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL fc_ready0 got=%b exp=001", req_ready); end
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    rx_valid = 1'b1; rx_data = 8'h5A; req_data = 24'h000032; req_last = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL fc_wait_busy got=%b exp=000", req_ready); end
    tick();
    tx_busy = 1'b0;
    #1;
    checks++; if (blocked !== 1'b1) begin errors++; $display("FAIL fc_blocked got=%b exp=1", blocked); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL fc_block_ready got=%b exp=000", req_ready); end
    tick();
    rx_valid = 1'b1; rx_data = 8'h41;
    #1;
    checks++; if (req_ready !== 3'b000 || tx_write !== 1'b0 || grant !== 3'b001) begin errors++; $display("FAIL fc_locked got=%b/%b/%b exp=000/0/001", req_ready, tx_write, grant); end
    tick();
    rx_valid = 1'b1; rx_data = 8'h5A;
    #1;
    checks++; if (blocked !== 1'b1) begin errors++; $display("FAIL fc_other_byte got=%b exp=1", blocked); end
    tick();
    rx_valid = 1'b1; rx_data = 8'h7A;
    #1;
    checks++; if (blocked !== 1'b1 || req_ready !== 3'b000 || tx_write !== 1'b0) begin errors++; $display("FAIL fc_still_blocked got=%b/%b/%b exp=1/000/0", blocked, req_ready, tx_write); end
    tick(); #1;
    checks++; if (blocked !== 1'b0 || req_ready !== 3'b001) begin errors++; $display("FAIL fc_unblock got=%b/%b exp=0/001", blocked, req_ready); end
    tick();
    req_valid = 3'b000;
    #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'h32) begin errors++; $display("FAIL fc_byte2 got=%b/%h exp=1/32", tx_write, tx_data); end
  endtask
  task automatic test_busy_stretch();
    int bad = 0;
    do_reset();
    req_valid = 3'b001; req_data = 24'h006655; req_last = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL busy_ready0 got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b010;
    #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL busy_issue got=%b/%h exp=1/55", tx_write, tx_data); end
    tick();
    tx_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready !== 3'b000 || tx_write !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_quiet got=%0d exp=0", bad); end
    tx_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL busy_release got=%b exp=010", req_ready); end
    tick();
    req_valid = 3'b000;
    #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'h66) begin errors++; $display("FAIL busy_next got=%b/%h exp=1/66", tx_write, tx_data); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    req_valid = 3'b100; req_data = 24'h770088; req_last = 3'b001;
    rx_valid = 1'b1; rx_data = 8'h5A;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rmid_ready got=%b exp=100", req_ready); end
    tick();
    tick();
    #1;
    checks++; if (grant !== 3'b100 || blocked !== 1'b1) begin errors++; $display("FAIL rmid_hold got=%b/%b exp=100/1", grant, blocked); end
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000 || tx_write !== 1'b0 || tx_data !== 8'h00 || grant !== 3'b000 || blocked !== 1'b0) begin
      errors++; $display("FAIL rmid_zero got=%b/%b/%h/%b/%b exp=000/0/00/000/0", req_ready, tx_write, tx_data, grant, blocked);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rmid_winner got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    #1;
    checks++; if (tx_write !== 1'b1 || tx_data !== 8'h88) begin errors++; $display("FAIL rmid_issue got=%b/%h exp=1/88", tx_write, tx_data); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_flow_control();
    test_busy_stretch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
